// File: rtl/pico_mem_responder.sv
// pico_mem_responder: PicoRV32 native-bus word RAM with wait states, abort, preload and counters.
module pico_mem_responder #(
  parameter int MEM_WORDS   = 128,
  parameter int ADDR_W      = 9,
  parameter int WAIT_STATES = 0,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_valid,
  input  logic              mem_instr,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_wstrb,
  output logic              mem_ready,
  output logic [31:0]       mem_rdata,
  input  logic              load_en,
  input  logic [ADDR_W-3:0] load_addr,
  input  logic [31:0]       load_data,
  output logic              err,
  output logic [CNT_W-1:0]  fetch_cnt,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic [CNT_W-1:0]  wr_cnt
);
  localparam int IW = ADDR_W - 2;
  localparam int MB = MEM_WORDS > 1 ? $clog2(MEM_WORDS) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0] wstrb_q, wstrb_d;
  logic instr_q, instr_d;
  logic [3:0] wait_q, wait_d;
  logic ready_q, err_q;
  logic [31:0] rdata_q;
  logic [CNT_W-1:0] fetch_q, rd_q, wr_q;
  logic [31:0] mem [MEM_WORDS];
  logic hit, load_ok, accept, resp;
  logic unused_ok;
  assign unused_ok = ^mem_addr[1:0];
  assign hit     = 32'(idx_q) < MEM_WORDS;
  assign resp    = state_q == RESP;
  assign load_ok = load_en && (reset || state_q == IDLE) && 32'(load_addr) < MEM_WORDS;
  // the ready cycle blocks acceptance so a still-held request is not served twice
  assign accept  = state_q == IDLE && mem_valid && !load_en && !ready_q;
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return &c ? c : c + 1'b1;
  endfunction
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    instr_d = instr_q;
    wait_d  = wait_q;
    case (state_q)
      IDLE: if (accept) begin
        idx_d   = mem_addr[ADDR_W-1:2];
        wdata_d = mem_wdata;
        wstrb_d = mem_wstrb;
        instr_d = mem_instr;
        wait_d  = 4'(WAIT_STATES - 1);
        state_d = WAIT_STATES == 0 ? RESP : WAIT;
      end
      WAIT: begin
        state_d = !mem_valid ? IDLE : wait_q == 4'd0 ? RESP : WAIT;
        wait_d  = wait_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    state_q <= reset ? IDLE : state_d;
    idx_q   <= idx_d;
    wdata_q <= wdata_d;
    wstrb_q <= wstrb_d;
    instr_q <= instr_d;
    wait_q  <= wait_d;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      fetch_q <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
    end else begin
      ready_q <= resp;
      err_q   <= resp && !hit;
      rdata_q <= resp && hit ? mem[idx_q[MB-1:0]] : '0;
      if (resp && hit) begin
        if (instr_q) fetch_q <= sat_inc(fetch_q);
        else if (|wstrb_q) wr_q <= sat_inc(wr_q);
        else rd_q <= sat_inc(rd_q);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (load_ok) mem[load_addr[MB-1:0]] <= load_data;
    else if (!reset && resp && hit)
      for (int b = 0; b < 4; b++)
        if (wstrb_q[b]) mem[idx_q[MB-1:0]][8*b +: 8] <= wdata_q[8*b +: 8];
  end
  assign mem_ready = ready_q;
  assign mem_rdata = rdata_q;
  assign err       = err_q;
  assign fetch_cnt = fetch_q;
  assign rd_cnt    = rd_q;
  assign wr_cnt    = wr_q;
endmodule

// File: tb/tb_pico_mem_responder.sv
// tb_pico_mem_responder: two responder configurations driven by directed and random traffic against a word-array model.
module tb_pico_mem_responder;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst[2], valid[2], instr[2], ld_en[2], ready[2], err[2];
  logic [8:0] addr[2];
  logic [31:0] wdata[2], ld_data[2], rdata[2];
  logic [3:0] wstrb[2];
  logic [6:0] ld_addr[2];
  logic [15:0] fc0, rc0, wc0;
  logic [2:0] fc1, rc1, wc1;
  int total = 0, bad = 0;
  logic [31:0] last_rd;
  logic [31:0] mm[2][128];
  int cf[2], cr[2], cw[2];
  int ws[2] = '{0, 3};
  int mw[2] = '{128, 64};
  int cmax[2] = '{65535, 7};

  pico_mem_responder #(.MEM_WORDS(128), .ADDR_W(9), .WAIT_STATES(0), .CNT_W(16)) u0 (
    .clk(clk), .reset(rst[0]), .mem_valid(valid[0]), .mem_instr(instr[0]), .mem_addr(addr[0]),
    .mem_wdata(wdata[0]), .mem_wstrb(wstrb[0]), .mem_ready(ready[0]), .mem_rdata(rdata[0]),
    .load_en(ld_en[0]), .load_addr(ld_addr[0]), .load_data(ld_data[0]), .err(err[0]),
    .fetch_cnt(fc0), .rd_cnt(rc0), .wr_cnt(wc0));
  pico_mem_responder #(.MEM_WORDS(64), .ADDR_W(9), .WAIT_STATES(3), .CNT_W(3)) u1 (
    .clk(clk), .reset(rst[1]), .mem_valid(valid[1]), .mem_instr(instr[1]), .mem_addr(addr[1]),
    .mem_wdata(wdata[1]), .mem_wstrb(wstrb[1]), .mem_ready(ready[1]), .mem_rdata(rdata[1]),
    .load_en(ld_en[1]), .load_addr(ld_addr[1]), .load_data(ld_data[1]), .err(err[1]),
    .fetch_cnt(fc1), .rd_cnt(rc1), .wr_cnt(wc1));

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_cnt(int u);
    int ef = cf[u] > cmax[u] ? cmax[u] : cf[u];
    int er = cr[u] > cmax[u] ? cmax[u] : cr[u];
    int ew = cw[u] > cmax[u] ? cmax[u] : cw[u];
    check("fetch_cnt", u == 0 ? 32'(fc0) : 32'(fc1), 32'(ef));
    check("rd_cnt", u == 0 ? 32'(rc0) : 32'(rc1), 32'(er));
    check("wr_cnt", u == 0 ? 32'(wc0) : 32'(wc1), 32'(ew));
  endtask

  task automatic load(int u, int idx, logic [31:0] d);
    ld_en[u] = 1; ld_addr[u] = 7'(idx); ld_data[u] = d;
    @(negedge clk);
    ld_en[u] = 0;
    if (idx < mw[u]) mm[u][idx] = d;
  endtask

  task automatic model_access(int u, int idx, logic [31:0] d, logic [3:0] s, logic i);
    if (idx >= mw[u]) return;
    for (int b = 0; b < 4; b++) if (s[b]) mm[u][idx][8*b +: 8] = d[8*b +: 8];
    if (i) cf[u]++;
    else if (s != 0) cw[u]++;
    else cr[u]++;
  endtask

  task automatic access(int u, logic [8:0] a, logic [31:0] d, logic [3:0] s, logic i, bit hold);
    int idx = int'(a[8:2]);
    logic [31:0] exp = idx < mw[u] ? mm[u][idx] : 32'h0;
    int n = 0;
    bit seen = 0;
    valid[u] = 1; addr[u] = a; wdata[u] = d; wstrb[u] = s; instr[u] = i;
    do begin @(negedge clk); n++; end while (!ready[u] && n < 40);
    check("latency", n, ws[u] + 2);
    check("rdata", rdata[u], exp);
    check("err", 32'(err[u]), 32'(idx >= mw[u]));
    last_rd = rdata[u];
    model_access(u, idx, d, s, i);
    if (hold) begin
      @(negedge clk);
      seen |= ready[u];
    end
    valid[u] = 0;
    @(negedge clk);
    check("err_pulse", 32'(err[u]), 0);
    seen |= ready[u];
    if (hold) repeat (ws[u] + 2) begin @(negedge clk); seen |= ready[u]; end
    check("no_dup_ready", 32'(seen), 0);
    check_cnt(u);
  endtask

  task automatic abort(int u, logic [8:0] a, logic [31:0] d, logic [3:0] s, logic i, int k);
    bit seen = 0;
    valid[u] = 1; addr[u] = a; wdata[u] = d; wstrb[u] = s; instr[u] = i;
    repeat (k) begin @(negedge clk); seen |= ready[u]; end
    valid[u] = 0;
    repeat (ws[u] + 3) begin @(negedge clk); seen |= ready[u]; end
    check("abort_no_ready", 32'(seen), 0);
    check_cnt(u);
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      rst[u] = 1; valid[u] = 0; instr[u] = 0; ld_en[u] = 0; addr[u] = 0;
      wdata[u] = 0; wstrb[u] = 0; ld_addr[u] = 0; ld_data[u] = 0;
      cf[u] = 0; cr[u] = 0; cw[u] = 0;
    end
    repeat (2) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      check("rst_ready", 32'(ready[u]), 0);
      check("rst_rdata", rdata[u], 0);
      check("rst_err", 32'(err[u]), 0);
      check_cnt(u);
      rst[u] = 0;
    end
    for (int u = 0; u < 2; u++)
      for (int w = 0; w < mw[u]; w++) load(u, w, $urandom);
    load(1, 100, 32'hCAFEF00D);
    // directed: fetch, partial write, readback on the zero-wait instance
    load(0, 0, 32'h3fc00093);
    access(0, 9'h000, 32'h0, 4'b0000, 1, 0);
    check("plan_fetch", last_rd, 32'h3fc00093);
    check("plan_fcnt", 32'(fc0), 1);
    load(0, 127, 32'hAABBCCDD);
    access(0, 9'h1FC, 32'h12345678, 4'b0011, 0, 0);
    check("plan_wr_old", last_rd, 32'hAABBCCDD);
    access(0, 9'h1FC, 32'h0, 4'b0000, 0, 1);
    check("plan_rd_new", last_rd, 32'hAABB5678);
    check("plan_wcnt", 32'(wc0), 1);
    check("plan_rcnt", 32'(rc0), 1);
    // load has priority over a simultaneous request, which then waits a cycle
    begin
      int n = 0;
      ld_en[0] = 1; ld_addr[0] = 7'd9; ld_data[0] = 32'h0BADBEEF;
      valid[0] = 1; addr[0] = 9'h024; wstrb[0] = 0; instr[0] = 0;
      @(negedge clk);
      ld_en[0] = 0;
      do begin @(negedge clk); n++; end while (!ready[0] && n < 40);
      check("ld_prio_lat", n, 2);
      check("ld_prio_rd", rdata[0], 32'h0BADBEEF);
      mm[0][9] = 32'h0BADBEEF; cr[0]++;
      valid[0] = 0;
      @(negedge clk);
      check_cnt(0);
    end
    // three-wait instance: latency, held valid, abort, out-of-range
    access(1, 9'h000, 32'h0, 4'b0000, 0, 1);
    abort(1, 9'h010, 32'hFFFFFFFF, 4'b1111, 0, 1);
    access(1, 9'h010, 32'h0, 4'b0000, 0, 0);
    access(1, 9'h100, 32'h0, 4'b0000, 0, 0);
    check("oor_rdata", last_rd, 0);
    access(1, 9'h100, 32'h11111111, 4'b1111, 0, 0);
    access(1, 9'h000, 32'h0, 4'b0000, 0, 0);
    // reset during a pending write, with a preload issued under reset
    begin
      bit seen = 0;
      valid[1] = 1; addr[1] = 9'h020; wdata[1] = 32'hDEADBEEF; wstrb[1] = 4'hF; instr[1] = 0;
      repeat (2) @(negedge clk);
      rst[1] = 1; valid[1] = 0;
      ld_en[1] = 1; ld_addr[1] = 7'd5; ld_data[1] = 32'h5A5A1234;
      @(negedge clk);
      ld_en[1] = 0; seen |= ready[1];
      @(negedge clk);
      rst[1] = 0; seen |= ready[1];
      mm[1][5] = 32'h5A5A1234; cf[1] = 0; cr[1] = 0; cw[1] = 0;
      check("rst_rdata_mid", rdata[1], 0);
      check("rst_err_mid", 32'(err[1]), 0);
      check_cnt(1);
      repeat (5) begin @(negedge clk); seen |= ready[1]; end
      check("rst_no_ready", 32'(seen), 0);
      access(1, 9'h020, 32'h0, 4'b0000, 0, 0);
      access(1, 9'h014, 32'h0, 4'b0000, 0, 0);
      check("rst_preload", last_rd, 32'h5A5A1234);
    end
    // random traffic; the 3-bit counters saturate along the way
    for (int u = 0; u < 2; u++)
      for (int t = 0; t < 80; t++) begin
        int op = $urandom_range(0, 99);
        logic [8:0] a = 9'($urandom_range(0, 511));
        logic [3:0] s = ($urandom % 2) ? 4'($urandom) : 4'h0;
        logic i = ($urandom % 4) == 0;
        if (op < 15) load(u, $urandom_range(0, 127), $urandom);
        else if (op < 30 && ws[u] > 0) abort(u, a, $urandom, s, i, $urandom_range(1, ws[u]));
        else access(u, a, $urandom, s, i, bit'($urandom % 2));
      end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
